// File: rtl/jstk_spi_reader_if.sv
// Pin- and data-side signals of the PmodJSTK poller, grouped as one bundle.
// The master modport is the reader itself; the slave modport is its environment.
interface jstk_spi_reader_if;
    logic        enable;
    logic [1:0]  led_cmd;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        ss_n;
    logic [39:0] jstk_data;
    logic        data_valid;
    logic        busy;

    modport master (
        input  enable, led_cmd, miso,
        output sclk, mosi, ss_n, jstk_data, data_valid, busy
    );

    modport slave (
        output enable, led_cmd, miso,
        input  sclk, mosi, ss_n, jstk_data, data_valid, busy
    );
endinterface

// File: rtl/jstk_spi_reader.sv
// Periodic SPI mode-0 poller for the PmodJSTK: one 5-byte transaction per poll,
// the received packet is published whole with a single-cycle data_valid strobe.
module jstk_spi_reader #(
    parameter int SCLK_HALF   = 750,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    jstk_spi_reader_if.master  bus
);

    // state    | meaning
    // ST_IDLE  | ss_n high, poll timer running, wait for expiry and enable
    // ST_SETUP | ss_n low, sclk low, first MOSI bit presented
    // ST_SHIFT | clocking one byte, sclk_q selects low/high half
    // ST_GAP   | ss_n low, sclk idle between bytes
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP} state_t;

    localparam int TMR_MAX = (SS_SETUP > BYTE_GAP)
                           ? ((SS_SETUP > SCLK_HALF) ? SS_SETUP : SCLK_HALF)
                           : ((BYTE_GAP > SCLK_HALF) ? BYTE_GAP : SCLK_HALF);
    localparam int TMR_W  = $clog2(TMR_MAX + 1);
    localparam int POLL_W = $clog2(POLL_PERIOD + 1);

    localparam logic [TMR_W-1:0]  SETUP_LD = TMR_W'(SS_SETUP - 1);
    localparam logic [TMR_W-1:0]  HALF_LD  = TMR_W'(SCLK_HALF - 1);
    localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(BYTE_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LD  = POLL_W'(POLL_PERIOD);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        tx_q, tx_d;
    logic [39:0]       rx_q, rx_d;
    logic [39:0]       data_q, data_d;
    logic              sclk_q, sclk_d;
    logic              ss_n_q, ss_n_d;
    logic              valid_q, valid_d;
    logic              tmr_done;

    assign tmr_done = (tmr_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            poll_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            poll_q  <= poll_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        poll_d  = poll_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        sclk_d  = sclk_q;
        ss_n_d  = ss_n_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // poll timer counts down; zero means expired, which is also its reset value
                if (poll_q != '0) begin
                    poll_d = poll_q - POLL_W'(1);
                end
                if ((poll_q == '0) && bus.enable) begin
                    tx_d    = {6'b100000, bus.led_cmd};
                    ss_n_d  = 1'b0;
                    tmr_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_GAP: begin
                if (tmr_done) begin
                    tmr_d   = HALF_LD;
                    state_d = ST_SHIFT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!tmr_done) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[38:0], bus.miso};
                    tmr_d  = HALF_LD;
                end else begin
                    // falling edge: advance MOSI so it is settled for the whole next low half
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[6:0], 1'b0};
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        tmr_d = HALF_LD;
                    end else begin
                        bit_d = '0;
                        if (byte_q == 3'd4) begin
                            byte_d  = '0;
                            ss_n_d  = 1'b1;
                            data_d  = rx_q;
                            valid_d = 1'b1;
                            poll_d  = POLL_LD;
                            state_d = ST_IDLE;
                        end else begin
                            byte_d  = byte_q + 3'd1;
                            tmr_d   = GAP_LD;
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.sclk       = sclk_q;
    assign bus.mosi       = tx_q[7];
    assign bus.ss_n       = ss_n_q;
    assign bus.jstk_data  = data_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = ~ss_n_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Bench for jstk_spi_reader: slave model on the SPI pins plus a continuous protocol
// monitor, with scenario tasks comparing against packets and timing derived from the rules.
module tb_jstk_spi_reader;
    localparam int SH = 2;
    localparam int SU = 4;
    localparam int BG = 3;
    localparam int PP = 20;
    localparam int TXN_LEN = SU + 80 * SH + 4 * BG;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    jstk_spi_reader_if bus_if ();

    jstk_spi_reader #(
        .SCLK_HALF   (SH),
        .SS_SETUP    (SU),
        .BYTE_GAP    (BG),
        .POLL_PERIOD (PP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    int          checks = 0;
    int          failures = 0;
    logic [39:0] slave_pkt = '0;
    int          rise_cnt = 0, run = 0, exp_run = 0;
    int          fall_cyc = 0, rise_cyc = 0, fall_cnt = 0, txn_cnt = 0;
    int          last_dur = 0, last_rises = 0;
    logic [39:0] mosi_cap = '0, last_mosi = '0, prev_jstk = '0;
    logic        last_dv = 1'b0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    function automatic logic [39:0] exp_mosi(input logic [1:0] led);
        return {6'b100000, led, 32'h0};
    endfunction

    // Slave model and mode-0 protocol monitor, sampled on the falling clk edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                rise_cnt = 0;
                run      = 1;
            end else begin
                if (prev_ss && !bus_if.ss_n) begin
                    fall_cyc = cyc;
                    fall_cnt++;
                    rise_cnt = 0;
                    mosi_cap = '0;
                    run      = 1;
                end else if (!bus_if.ss_n) begin
                    if (bus_if.sclk === prev_sclk) begin
                        run++;
                    end else begin
                        if (bus_if.sclk)
                            exp_run = (rise_cnt == 0) ? SU + SH : ((rise_cnt % 8 == 0) ? BG + SH : SH);
                        else
                            exp_run = SH;
                        checks++;
                        if (run !== exp_run) begin
                            failures++;
                            $display("FAIL sclk_phase_len: got %0d cycles, expected %0d (rise %0d)", run, exp_run, rise_cnt);
                        end
                        run = 1;
                        if (bus_if.sclk) begin
                            checks++;
                            if (bus_if.mosi !== prev_mosi) begin
                                failures++;
                                $display("FAIL mosi_stable: mosi %b at rise, was %b before (rise %0d)", bus_if.mosi, prev_mosi, rise_cnt);
                            end
                            mosi_cap = {mosi_cap[38:0], bus_if.mosi};
                            rise_cnt++;
                        end
                    end
                end
                if (bus_if.ss_n !== prev_ss) begin
                    checks++;
                    if (bus_if.sclk !== 1'b0) begin
                        failures++;
                        $display("FAIL sclk_at_ss_edge: sclk=%b, expected 0", bus_if.sclk);
                    end
                end
                if (!prev_ss && bus_if.ss_n) begin
                    checks++;
                    if (run !== SH) begin
                        failures++;
                        $display("FAIL last_high_phase: got %0d cycles, expected %0d", run, SH);
                    end
                    last_dur   = cyc - fall_cyc;
                    last_rises = rise_cnt;
                    last_mosi  = mosi_cap;
                    last_dv    = bus_if.data_valid;
                    rise_cyc   = cyc;
                    txn_cnt++;
                end
                if (bus_if.ss_n) begin
                    checks++;
                    if (bus_if.sclk !== 1'b0) begin
                        failures++;
                        $display("FAIL sclk_idle: sclk=%b while ss_n high", bus_if.sclk);
                    end
                end
                checks++;
                if (bus_if.data_valid !== (!prev_ss && bus_if.ss_n)) begin
                    failures++;
                    $display("FAIL dv_timing: data_valid=%b, expected %b", bus_if.data_valid, (!prev_ss && bus_if.ss_n));
                end
                checks++;
                if (!bus_if.data_valid && (bus_if.jstk_data !== prev_jstk)) begin
                    failures++;
                    $display("FAIL jstk_hold: jstk_data %h changed from %h without data_valid", bus_if.jstk_data, prev_jstk);
                end
                checks++;
                if (bus_if.busy !== !bus_if.ss_n) begin
                    failures++;
                    $display("FAIL busy: busy=%b, expected %b", bus_if.busy, !bus_if.ss_n);
                end
            end
            bus_if.miso = (rise_cnt < 40) ? slave_pkt[39 - rise_cnt] : 1'b0;
            prev_ss   = bus_if.ss_n;
            prev_sclk = bus_if.sclk;
            prev_mosi = bus_if.mosi;
            prev_jstk = bus_if.jstk_data;
        end
    endtask

    task automatic wait_fall(input int start, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fall_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_txn(input int start, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txn_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rise_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.enable  = 1'b0;
        bus_if.led_cmd = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.ss_n !== 1'b1) begin failures++; $display("FAIL rst_ss_n: got %b expected 1", bus_if.ss_n); end
        checks++;
        if (bus_if.sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk: got %b expected 0", bus_if.sclk); end
        checks++;
        if (bus_if.mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi: got %b expected 0", bus_if.mosi); end
        checks++;
        if (bus_if.jstk_data !== 40'h0) begin failures++; $display("FAIL rst_jstk: got %h expected 0", bus_if.jstk_data); end
        checks++;
        if (bus_if.data_valid !== 1'b0) begin failures++; $display("FAIL rst_dv: got %b expected 0", bus_if.data_valid); end
        checks++;
        if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus_if.busy); end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (fall_cnt !== 0) begin failures++; $display("FAIL idle_no_enable: %0d transactions started, expected 0", fall_cnt); end
    endtask

    task automatic test_basic();
        int c, s, f;
        bit ok;
        @(negedge clk);
        slave_pkt      = 40'h1203340205;
        bus_if.led_cmd = 2'b01;
        bus_if.enable  = 1'b1;
        c = cyc; s = txn_cnt; f = fall_cnt;
        wait_fall(f, 10, ok);
        checks++;
        if (!ok || fall_cyc !== c + 1) begin failures++; $display("FAIL basic_start: ok=%0d fall at %0d, expected %0d", ok, fall_cyc, c + 1); end
        wait_txn(s, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done: transaction did not finish, ok=%0d expected 1", ok); end
        checks++;
        if (last_mosi !== exp_mosi(2'b01)) begin failures++; $display("FAIL basic_mosi: got %h expected %h", last_mosi, exp_mosi(2'b01)); end
        checks++;
        if (last_rises !== 40) begin failures++; $display("FAIL basic_rises: got %0d expected 40", last_rises); end
        checks++;
        if (last_dur !== TXN_LEN) begin failures++; $display("FAIL basic_ss_len: got %0d expected %0d", last_dur, TXN_LEN); end
        checks++;
        if (bus_if.jstk_data !== 40'h1203340205) begin failures++; $display("FAIL basic_data: got %h expected 1203340205", bus_if.jstk_data); end
        checks++;
        if (last_dv !== 1'b1) begin failures++; $display("FAIL basic_dv: got %b expected 1 at ss_n rise", last_dv); end
    endtask

    task automatic test_poll_spacing();
        int r, s, f;
        bit ok;
        logic [39:0] old_pkt;
        r = rise_cyc; s = txn_cnt; f = fall_cnt;
        old_pkt   = slave_pkt;
        slave_pkt = 40'hFF03000001;
        wait_fall(f, 60, ok);
        checks++;
        if (!ok || (fall_cyc - r) !== PP + 1) begin failures++; $display("FAIL poll_spacing: ok=%0d gap %0d, expected %0d", ok, fall_cyc - r, PP + 1); end
        checks++;
        if (bus_if.jstk_data !== old_pkt) begin failures++; $display("FAIL poll_hold: got %h expected %h", bus_if.jstk_data, old_pkt); end
        wait_txn(s, 400, ok);
        checks++;
        if (!ok || bus_if.jstk_data !== 40'hFF03000001) begin failures++; $display("FAIL poll_data: ok=%0d got %h expected ff03000001", ok, bus_if.jstk_data); end
        checks++;
        if (last_dur !== TXN_LEN) begin failures++; $display("FAIL poll_ss_len: got %0d expected %0d", last_dur, TXN_LEN); end
    endtask

    task automatic test_enable_led();
        int c, s, f;
        bit ok;
        logic [39:0] pkt, pkt2;
        pkt = {8'($urandom), 32'($urandom)};
        slave_pkt = pkt;
        s = txn_cnt; f = fall_cnt;
        wait_fall(f, 60, ok);
        wait_rises(16, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL en_reach_byte3: ok=%0d expected 1", ok); end
        bus_if.enable  = 1'b0;
        bus_if.led_cmd = 2'b10;
        wait_txn(s, 400, ok);
        checks++;
        if (!ok || bus_if.jstk_data !== pkt) begin failures++; $display("FAIL en_complete: ok=%0d got %h expected %h", ok, bus_if.jstk_data, pkt); end
        checks++;
        if (last_mosi !== exp_mosi(2'b01)) begin failures++; $display("FAIL en_led_ignored: got %h expected %h", last_mosi, exp_mosi(2'b01)); end
        checks++;
        if (last_dv !== 1'b1) begin failures++; $display("FAIL en_dv: got %b expected 1", last_dv); end
        f = fall_cnt;
        repeat (100) @(negedge clk);
        checks++;
        if (fall_cnt !== f) begin failures++; $display("FAIL en_no_start: %0d starts, expected %0d", fall_cnt, f); end
        pkt2 = {8'($urandom), 32'($urandom)};
        slave_pkt = pkt2;
        @(negedge clk);
        bus_if.enable = 1'b1;
        c = cyc; s = txn_cnt;
        wait_fall(f, 10, ok);
        checks++;
        if (!ok || fall_cyc !== c + 1) begin failures++; $display("FAIL en_restart: ok=%0d fall at %0d, expected %0d", ok, fall_cyc, c + 1); end
        wait_txn(s, 400, ok);
        checks++;
        if (!ok || last_mosi !== exp_mosi(2'b10)) begin failures++; $display("FAIL en_new_led: ok=%0d got %h expected %h", ok, last_mosi, exp_mosi(2'b10)); end
        checks++;
        if (bus_if.jstk_data !== pkt2) begin failures++; $display("FAIL en_data2: got %h expected %h", bus_if.jstk_data, pkt2); end
    endtask

    task automatic test_reset_mid();
        int c, s, f;
        bit ok;
        logic [39:0] pkt;
        slave_pkt = {8'($urandom), 32'($urandom)};
        s = txn_cnt; f = fall_cnt;
        wait_fall(f, 60, ok);
        wait_rises(12, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rm_reach_bit: ok=%0d expected 1", ok); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.ss_n !== 1'b1 || bus_if.sclk !== 1'b0 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_pins: ss_n=%b sclk=%b busy=%b, expected 1 0 0", bus_if.ss_n, bus_if.sclk, bus_if.busy);
        end
        checks++;
        if (bus_if.jstk_data !== 40'h0 || bus_if.data_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_data: jstk=%h dv=%b, expected 0 0", bus_if.jstk_data, bus_if.data_valid);
        end
        reset = 1'b0;
        c = cyc; f = fall_cnt;
        pkt = {8'($urandom), 32'($urandom)};
        slave_pkt = pkt;
        wait_fall(f, 10, ok);
        checks++;
        if (!ok || fall_cyc !== c + 1) begin failures++; $display("FAIL rm_restart: ok=%0d fall at %0d, expected %0d", ok, fall_cyc, c + 1); end
        wait_txn(s, 400, ok);
        checks++;
        if (!ok || txn_cnt !== s + 1) begin failures++; $display("FAIL rm_txn_count: ok=%0d got %0d expected %0d", ok, txn_cnt, s + 1); end
        checks++;
        if (last_dur !== TXN_LEN || last_rises !== 40) begin failures++; $display("FAIL rm_full_txn: len %0d rises %0d, expected %0d 40", last_dur, last_rises, TXN_LEN); end
        checks++;
        if (last_mosi !== exp_mosi(2'b10) || bus_if.jstk_data !== pkt) begin
            failures++;
            $display("FAIL rm_payload: mosi %h data %h, expected %h %h", last_mosi, bus_if.jstk_data, exp_mosi(2'b10), pkt);
        end
    endtask

    task automatic test_random();
        int s;
        bit ok;
        logic [39:0] pkt;
        logic [1:0]  led;
        for (int n = 0; n < 4; n++) begin
            pkt = {8'($urandom), 32'($urandom)};
            led = 2'($urandom_range(0, 3));
            slave_pkt      = pkt;
            bus_if.led_cmd = led;
            s = txn_cnt;
            wait_txn(s, 500, ok);
            checks++;
            if (!ok || bus_if.jstk_data !== pkt) begin failures++; $display("FAIL rand_data[%0d]: ok=%0d got %h expected %h", n, ok, bus_if.jstk_data, pkt); end
            checks++;
            if (last_mosi !== exp_mosi(led)) begin failures++; $display("FAIL rand_mosi[%0d]: got %h expected %h", n, last_mosi, exp_mosi(led)); end
            checks++;
            if (last_dur !== TXN_LEN || last_rises !== 40) begin failures++; $display("FAIL rand_timing[%0d]: len %0d rises %0d, expected %0d 40", n, last_dur, last_rises, TXN_LEN); end
        end
    endtask

    initial begin
        bus_if.miso    = 1'b0;
        bus_if.enable  = 1'b0;
        bus_if.led_cmd = 2'b00;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_poll_spacing();
        test_enable_led();
        test_reset_mid();
        test_random();
        bus_if.enable = 1'b0;
        repeat (250) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
